// File: rtl/output_backprop.sv
// Output-layer backward pass: owns the eight output weights, computes the signed error after each
// forward result and applies one gradient-descent weight update per cycle via a shared multiplier.
module output_backprop #(
  parameter logic [7:0]  W_INIT   = 8'd64,
  parameter int unsigned LR_SHIFT = 14,
  parameter int unsigned N_IN     = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [20:0] pred_i,
  input  logic [3:0]  target_i,
  input  logic [79:0] x_flat_i,
  output logic [63:0] w_flat_o,
  output logic [21:0] err_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        sat_o
);

  localparam int unsigned IdxW = $clog2(N_IN);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_IN - 1);

  typedef enum logic [1:0] {StIdle, StErr, StUpd, StDone} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [20:0]        pred_q;
  logic [3:0]         target_q;
  logic [9:0]         x_q [N_IN];
  logic signed [21:0] err_q, err_d;
  logic [7:0]         w_q [N_IN];
  logic               sat_q;

  logic               latch_en, err_en, upd_en;
  logic [9:0]         x_sel;
  logic [7:0]         w_sel;
  logic signed [32:0] prod, delta;
  logic signed [33:0] w_new;
  logic [7:0]         w_clamped;
  logic               clamp_hit;

  // Controller: a start arriving in DONE is taken on the DONE->IDLE edge so passes can chain.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    latch_en = 1'b0;
    err_en   = 1'b0;
    upd_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          latch_en = 1'b1;
          state_d  = StErr;
        end
      end
      StErr: begin
        err_en  = 1'b1;
        idx_d   = '0;
        state_d = StUpd;
      end
      StUpd: begin
        upd_en = 1'b1;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (start_i) begin
          latch_en = 1'b1;
          state_d  = StErr;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath: error, then w_k - ((err * x_k) >>> LR_SHIFT) with clamping to [0, 255].
  always_comb begin
    err_d     = $signed({1'b0, pred_q}) - $signed({11'd0, target_q, 7'd0});
    x_sel     = x_q[idx_q];
    w_sel     = w_q[idx_q];
    prod      = err_q * $signed({1'b0, x_sel});
    delta     = prod >>> LR_SHIFT;
    w_new     = $signed({26'd0, w_sel}) - $signed({delta[32], delta});
    clamp_hit = 1'b0;
    w_clamped = w_new[7:0];
    if (w_new[33]) begin
      w_clamped = 8'd0;
      clamp_hit = 1'b1;
    end else if (|w_new[32:8]) begin
      w_clamped = 8'd255;
      clamp_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      pred_q   <= '0;
      target_q <= '0;
      err_q    <= '0;
      sat_q    <= 1'b0;
      for (int i = 0; i < int'(N_IN); i++) begin
        x_q[i] <= '0;
        w_q[i] <= W_INIT;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (latch_en) begin
        pred_q   <= pred_i;
        target_q <= target_i;
        sat_q    <= 1'b0;
        for (int i = 0; i < int'(N_IN); i++) begin
          x_q[i] <= x_flat_i[i*10 +: 10];
        end
      end
      if (err_en) begin
        err_q <= err_d;
      end
      if (upd_en) begin
        w_q[idx_q] <= w_clamped;
        if (clamp_hit) begin
          sat_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_flat_o = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      w_flat_o[i*8 +: 8] = w_q[i];
    end
  end

  assign err_o  = err_q;
  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);
  assign sat_o  = sat_q;

endmodule

// File: tb/tb_output_backprop.sv
// Bench for output_backprop: table of full update passes checked through a scoreboard queue,
// plus hand-written handshake and mid-pass reset sequences.
module tb_output_backprop;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [20:0] pred = '0;
  logic [3:0]  target = '0;
  logic [79:0] x_flat = '0;
  logic [63:0] w_flat;
  logic [21:0] err;
  logic        busy, done, sat;

  output_backprop dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .pred_i   (pred),
    .target_i (target),
    .x_flat_i (x_flat),
    .w_flat_o (w_flat),
    .err_o    (err),
    .busy_o   (busy),
    .done_o   (done),
    .sat_o    (sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] err;
    logic [63:0] w;
    logic        sat;
  } exp_t;

  typedef struct {
    bit          rst_first;
    logic [20:0] pred;
    logic [3:0]  target;
    logic [79:0] x;
    logic [21:0] err;
    logic [63:0] w;
    logic        sat;
  } vec_t;

  exp_t sb[$];
  int   passes = 0;
  int   total = 0;

  logic [79:0] x_all;
  logic [79:0] x_one;
  logic [63:0] w64;
  vec_t        vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passes++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive a start for one edge and record what the pass should leave behind.
  task automatic start_pass(input logic [20:0] p, input logic [3:0] t, input logic [79:0] xv,
                            input exp_t e);
    @(negedge clk);
    pred   = p;
    target = t;
    x_flat = xv;
    start  = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_front(input string name);
    exp_t e;
    check({name, "_pending"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({name, "_err"}, err, e.err);
    check({name, "_w"}, w_flat, e.w);
    check({name, "_sat"}, sat, e.sat);
  endtask

  // Called on the negedge after the start edge; returns on the negedge where done is seen.
  task automatic wait_done(input string name, output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && cycles < 20) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    if (busy === 1'b1) busy_cnt++;
    check({name, "_done_seen"}, done, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, total);
    $fatal(1);
  end

  initial begin
    int   cyc, bcnt, extra;
    exp_t e;

    x_all = {8{10'h3FF}};
    x_one = 80'h3FF;
    w64   = {8{8'h40}};
    vecs[0] = '{1'b1, 21'd1920, 4'd15, x_all, 22'd0, w64, 1'b0};
    vecs[1] = '{1'b1, 21'd0, 4'd1, x_one, -22'sd128, {{7{8'h40}}, 8'h48}, 1'b0};
    vecs[2] = '{1'b1, 21'd0, 4'd15, x_all, -22'sd1920, {8{8'hB8}}, 1'b0};
    vecs[3] = '{1'b0, 21'd0, 4'd15, x_all, -22'sd1920, {8{8'hFF}}, 1'b1};
    vecs[4] = '{1'b1, 21'd2097151, 4'd0, x_one, 22'd2097151, {{7{8'h40}}, 8'h00}, 1'b1};

    // Reset state while reset is held
    repeat (2) @(negedge clk);
    check("rst_w", w_flat, w64);
    check("rst_err", err, 22'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sat", sat, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].rst_first) do_reset();
      e = '{vecs[i].err, vecs[i].w, vecs[i].sat};
      start_pass(vecs[i].pred, vecs[i].target, vecs[i].x, e);
      wait_done($sformatf("vec%0d", i), cyc, bcnt);
      check($sformatf("vec%0d_latency", i), 64'(cyc), 64'd9);
      check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd10);
      check_front($sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done, 1'b0);
      check($sformatf("vec%0d_idle", i), busy, 1'b0);
    end

    // Handshake: starts at N+3 and N+9 ignored, start at N+10 accepted and clears sat
    do_reset();
    start_pass(21'd2097151, 4'd0, x_one, '{22'd2097151, {{7{8'h40}}, 8'h00}, 1'b1});
    repeat (2) @(negedge clk);
    pred   = 21'd0;
    target = 4'd15;
    x_flat = x_all;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check("hs_done_at_n9", done, 1'b1);
    check_front("hs_pass1");
    pred   = 21'd1920;
    target = 4'd15;
    x_flat = x_all;
    sb.push_back('{22'd0, {{7{8'h40}}, 8'h00}, 1'b0});
    @(negedge clk);
    start = 1'b0;
    check("hs_sat_cleared", sat, 1'b0);
    check("hs_busy_n10", busy, 1'b1);
    check("hs_done_n10", done, 1'b0);
    wait_done("hs_pass2", cyc, bcnt);
    check("hs_pass2_latency", 64'(cyc), 64'd9);
    check_front("hs_pass2");
    extra = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("hs_no_extra_pass", 64'(extra), 64'd0);

    // Reset between edges N+4 and N+5 abandons the pass
    do_reset();
    start_pass(21'd2097151, 4'd0, x_one, '{22'd2097151, {{7{8'h40}}, 8'h00}, 1'b1});
    repeat (4) @(negedge clk);
    check("mid_w0_updated", w_flat[7:0], 8'h00);
    #1 rst = 1'b0;
    #1;
    check("mid_w_restored", w_flat, w64);
    check("mid_busy", busy, 1'b0);
    check("mid_done", done, 1'b0);
    check("mid_err", err, 22'd0);
    check("mid_sat", sat, 1'b0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst   = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    check("mid_no_done", 64'(extra), 64'd0);
    start_pass(21'd0, 4'd1, x_one, '{-22'sd128, {{7{8'h40}}, 8'h48}, 1'b0});
    wait_done("mid_after", cyc, bcnt);
    check("mid_after_latency", 64'(cyc), 64'd9);
    check_front("mid_after");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
